// File: rtl/fnd_pkg.sv
// Shared constants, FSM encoding and small helpers for the 7-segment scan driver.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_DISP   = 9999;

  // Active-low segment patterns, bit 0 = a .. bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Nibble to segment pattern; anything above 9 shows as blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to every BCD nibble that is 5 or more.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter.
// Handshake: start is honoured only in IDLE (busy=0). busy stays high from the
// accepting edge until the edge on which done is seen; done is high for exactly
// one cycle, during which bcd holds the finished result.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output conv_state_t      state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  conv_state_t          state_next;
  logic [CW-1:0]        cnt;
  logic [WIDTH+15:0]    sr;
  logic [WIDTH+15:0]    sr_adj;

  assign sr_adj = {bcd_adjust(sr[WIDTH+15:WIDTH]), sr[WIDTH-1:0]};
  assign bcd    = sr[WIDTH+15:WIDTH];

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_next = COMMIT;
      end
      COMMIT: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register and iteration counter: one adjust+shift per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      sr  <= {16'd0, bin};
      cnt <= '0;
    end else if (state == SHIFT) begin
      sr  <= sr_adj << 1;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed 7-segment driver: binary in, BCD conversion, digit scan,
// leading-zero blanking and per-digit decimal points.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int WIDTH    = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_load,
  input  logic             lz_blank,
  input  logic [3:0]       dp,
  output logic             busy,
  output logic             ovf,
  output logic [7:0]       seg,
  output logic [3:0]       an
);

  localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0]   SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_DISP);

  conv_state_t      conv_state;
  logic             conv_busy;
  logic             conv_done;
  logic [15:0]      conv_bcd;
  logic             accept;
  logic             over;
  logic [WIDTH-1:0] clamped;

  logic [15:0]      digits;
  logic [SCW-1:0]   scan_cnt;
  logic [1:0]       idx;
  logic             z3, z2, z1;
  logic [3:0]       nib;
  logic             lz_zero;
  logic [6:0]       seg_next;

  assign accept  = in_load && (conv_state == IDLE);
  assign over    = in_data > MAX_W;
  assign clamped = over ? MAX_W : in_data;
  assign busy    = conv_busy;

  bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .bin   (clamped),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .state (conv_state)
  );

  // Overflow flag tracks the most recently accepted load only.
  always_ff @(posedge clk) begin
    if (!reset)      ovf <= 1'b0;
    else if (accept) ovf <= over;
  end

  // Displayed digits change on one edge only, so no partial value is ever shown.
  always_ff @(posedge clk) begin
    if (!reset)         digits <= '0;
    else if (conv_done) digits <= conv_bcd;
  end

  // Free-running scan divider and digit index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  assign z3 = (digits[15:12] == 4'd0);
  assign z2 = z3 && (digits[11:8] == 4'd0);
  assign z1 = z2 && (digits[7:4] == 4'd0);

  // Select the active digit and apply blanking; digit 0 is never blanked.
  always_comb begin
    nib     = 4'd0;
    lz_zero = 1'b0;
    case (idx)
      2'd0: nib = digits[3:0];
      2'd1: begin nib = digits[7:4];   lz_zero = z1; end
      2'd2: begin nib = digits[11:8];  lz_zero = z2; end
      2'd3: begin nib = digits[15:12]; lz_zero = z3; end
      default: nib = 4'd0;
    endcase
    seg_next = (lz_blank && lz_zero) ? SEG_BLANK : seg_encode(nib);
  end

  // Registered display outputs; dp is shown even on a blanked digit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      seg <= {~dp[idx], seg_next};
      an  <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: behavioural display model plus directed and random loads.
module tb_fnd_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int WIDTH    = 14;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_load;
  logic             lz_blank;
  logic [3:0]       dp;
  logic             busy;
  logic             ovf;
  logic [7:0]       seg;
  logic [3:0]       an;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  fnd_scan_driver #(.SCAN_DIV(SCAN_DIV), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_load  (in_load),
    .lz_blank (lz_blank),
    .dp       (dp),
    .busy     (busy),
    .ovf      (ovf),
    .seg      (seg),
    .an       (an)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int pow10(input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  // Expected segment byte for digit i of decimal value v.
  function automatic logic [7:0] model_seg(input int i, input int v, input logic lz, input logic [3:0] d);
    int p;
    int dig;
    logic blank;
    p     = pow10(i);
    dig   = (v / p) % 10;
    blank = lz && (i > 0) && (v < p);
    return {~d[i], blank ? 7'h7F : seg_of(dig)};
  endfunction

  logic [WIDTH-1:0] exp_q[$];
  int         m_val  = 0;
  int         m_cd   = 0;
  int         m_cnt  = 0;
  int         m_idx  = 0;
  logic       m_ovf  = 1'b0;
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_seg = 8'hFF;

  // Model: accepted loads are queued and appear on the display WIDTH+1 edges later.
  always @(posedge clk) begin
    if (!reset) begin
      m_val   <= 0;
      m_cd    <= 0;
      m_cnt   <= 0;
      m_idx   <= 0;
      m_ovf   <= 1'b0;
      exp_an  <= 4'hF;
      exp_seg <= 8'hFF;
      exp_q.delete();
    end else begin
      exp_an  <= ~(4'b0001 << m_idx);
      exp_seg <= model_seg(m_idx, m_val, lz_blank, dp);
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt <= 0;
        m_idx <= (m_idx + 1) % 4;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (m_cd != 0) begin
        m_cd <= m_cd - 1;
        if (m_cd == 1 && exp_q.size() > 0) m_val <= int'(exp_q.pop_front());
      end else if (in_load) begin
        exp_q.push_back((int'(in_data) > 9999) ? WIDTH'(9999) : in_data);
        m_ovf <= int'(in_data) > 9999;
        m_cd  <= WIDTH + 1;
      end
    end
  end

  // Scoreboard compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {15'd0, busy}, {15'd0, (m_cd != 0)});
      check("ovf",  {15'd0, ovf},  {15'd0, m_ovf});
      check("an",   {12'd0, an},   {12'd0, exp_an});
      check("seg",  {8'd0, seg},   {8'd0, exp_seg});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input int v);
    @(negedge clk);
    in_data = WIDTH'(v);
    in_load = 1'b1;
    @(negedge clk);
    in_load = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("idle_timeout", 16'd1, 16'd0);
  endtask

  // Wait until digit with the given an pattern is on, then compare its seg byte.
  task automatic check_digit(input string tag, input logic [3:0] an_val, input logic [7:0] seg_exp);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (an == an_val) found = 1'b1;
    end
    if (!found) check({tag, "_timeout"}, {12'd0, an}, {12'd0, an_val});
    else        check(tag, {8'd0, seg}, {8'd0, seg_exp});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bcnt;
    int v;
    reset    = 1'b0;
    in_data  = '0;
    in_load  = 1'b0;
    lz_blank = 1'b0;
    dp       = 4'b0000;

    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_seg", {8'd0, seg}, 16'h00FF);
    check("rst_an",  {12'd0, an}, 16'h000F);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_an",  {12'd0, an}, 16'h000E);
    check("post_rst_seg", {8'd0, seg}, 16'h00C0);
    check_digit("zero_d3", 4'b0111, 8'hC0);

    // 1234, busy duration and digit patterns.
    do_load(1234);
    bcnt = 0;
    while (busy && bcnt < 100) begin
      bcnt++;
      @(negedge clk);
    end
    check("busy_len", 16'(bcnt), 16'(WIDTH + 1));
    check_digit("d0_1234", 4'b1110, 8'h99);
    check_digit("d1_1234", 4'b1101, 8'hB0);
    check_digit("d2_1234", 4'b1011, 8'hA4);
    check_digit("d3_1234", 4'b0111, 8'hF9);

    // 7 with leading-zero blanking and dp on digit 2.
    @(negedge clk);
    lz_blank = 1'b1;
    dp       = 4'b0100;
    do_load(7);
    wait_idle();
    check_digit("d0_7", 4'b1110, 8'hF8);
    check_digit("d1_7", 4'b1101, 8'hFF);
    check_digit("d2_7", 4'b1011, 8'h7F);
    check_digit("d3_7", 4'b0111, 8'hFF);

    // Overflow clamps to 9999, next normal load clears it.
    @(negedge clk);
    lz_blank = 1'b0;
    dp       = 4'b0000;
    do_load(12000);
    wait_idle();
    check("ovf_set", {15'd0, ovf}, 16'd1);
    check_digit("d1_ovf", 4'b1101, 8'h90);
    check_digit("d3_ovf", 4'b0111, 8'h90);
    do_load(5);
    wait_idle();
    check("ovf_clr", {15'd0, ovf}, 16'd0);

    // A load during conversion is dropped.
    do_load(1234);
    @(negedge clk);
    do_load(42);
    wait_idle();
    check_digit("d0_drop", 4'b1110, 8'h99);
    check_digit("d3_drop", 4'b0111, 8'hF9);

    // Reset in the middle of SHIFT: no commit, display back to zeros.
    do_load(9876);
    repeat (4) @(negedge clk);
    do_reset(2);
    check("busy_after_rst", {15'd0, busy}, 16'd0);
    check_digit("d3_after_rst", 4'b0111, 8'hC0);
    check_digit("d0_after_rst", 4'b1110, 8'hC0);

    // Random loads, settings, overlapping loads and occasional resets.
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      lz_blank = 1'($urandom_range(0, 1));
      dp       = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(9990, 16383);
        default: v = $urandom_range(0, 9999);
      endcase
      do_load(v);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        do_load($urandom_range(0, 16383));
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 10)) @(negedge clk);
        do_reset($urandom_range(1, 3));
      end
      wait_idle();
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
